// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, R-type funct codes,
// ALU control encodings and default widths.
package id_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_ALUCTR_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLT = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4
    } alu_op_e;

endpackage

// File: rtl/id_regfile.sv
// Register file: two asynchronous read ports, one write port, R0 hardwired to zero.
// Optional write-through read when ID_WB_BYPASS_EN is defined.
module id_regfile
    import id_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [2**REG_AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) mem[i] <= '0;
        end else if (wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Bypass takes priority over the array; R0 overrides everything.
    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (BYPASS && wa != '0 && wa == ra1) rd1 = wd;
        if (BYPASS && wa != '0 && wa == ra2) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register read, decode, load-use/branch hazard stall,
// beq/j redirect, and the D/X pipeline register. ID_WB_BYPASS_EN selects write-through reads.
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int ALUCTR_W = DEF_ALUCTR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         IR,
    input  logic                IR_valid,
    input  logic [DATA_W-1:0]   PC,
    input  logic [REG_AW-1:0]   MW_RD,
    input  logic [DATA_W-1:0]   MW_ALUout,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic [DATA_W-1:0]   IMM,
    output logic [REG_AW-1:0]   RD,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                ALUsrc,
    output logic                DX_lwFlag,
    output logic                DX_swFlag,
    output logic                DX_valid,
    output logic                stall,
    output logic                redirect,
    output logic [DATA_W-1:0]   redirect_pc
);

    logic [5:0]          op, funct;
    logic [REG_AW-1:0]   rs, rt, rd_f;
    logic [DATA_W-1:0]   imm_ext, rs_val, rt_val, pc4;
    logic                is_r, is_lw, is_sw, is_beq, is_j;
    logic                uses_rs, uses_rt, lw_hz, br_hz, issue;
    logic [ALUCTR_W-1:0] alu_nxt;

    assign op      = IR[31:26];
    assign funct   = IR[5:0];
    assign rs      = REG_AW'(IR[25:21]);
    assign rt      = REG_AW'(IR[20:16]);
    assign rd_f    = REG_AW'(IR[15:11]);
    assign imm_ext = {{(DATA_W-16){IR[15]}}, IR[15:0]};

    id_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rs_val),
        .rd2 (rt_val),
        .wa  (MW_RD),
        .wd  (MW_ALUout)
    );

    always_comb begin
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        alu_nxt = ALUCTR_W'(ALU_ADD);
        case (op)
            OP_RTYPE: begin
                is_r = 1'b1;
                case (funct)
                    FN_ADD:  alu_nxt = ALUCTR_W'(ALU_ADD);
                    FN_SUB:  alu_nxt = ALUCTR_W'(ALU_SUB);
                    FN_SLT:  alu_nxt = ALUCTR_W'(ALU_SLT);
                    FN_AND:  alu_nxt = ALUCTR_W'(ALU_AND);
                    FN_OR:   alu_nxt = ALUCTR_W'(ALU_OR);
                    default: is_r = 1'b0;
                endcase
            end
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    // Hazards only matter for operands the instruction actually reads.
    assign uses_rt = is_r | is_sw | is_beq;
    assign uses_rs = uses_rt | is_lw;
    assign lw_hz   = DX_valid & DX_lwFlag & (RD != '0) &
                     ((uses_rs & (RD == rs)) | (uses_rt & (RD == rt)));
    assign br_hz   = is_beq & DX_valid & (RD != '0) & ((RD == rs) | (RD == rt));
    assign stall   = IR_valid & (lw_hz | br_hz);
    assign issue   = IR_valid & ~stall & (is_r | is_lw | is_sw);

    assign pc4         = PC + DATA_W'(4);
    assign redirect    = IR_valid & ~stall & (is_j | (is_beq & (rs_val == rt_val)));
    assign redirect_pc = is_j ? {pc4[DATA_W-1:28], IR[25:0], 2'b00}
                              : pc4 + (imm_ext << 2);

    // ---- D/X pipeline register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            A         <= '0;
            B         <= '0;
            IMM       <= '0;
            RD        <= '0;
            ALUctr    <= '0;
            ALUsrc    <= 1'b0;
            DX_lwFlag <= 1'b0;
            DX_swFlag <= 1'b0;
            DX_valid  <= 1'b0;
        end else begin
            DX_valid  <= issue;
            DX_lwFlag <= issue & is_lw;
            DX_swFlag <= issue & is_sw;
            RD        <= !issue ? '0 : is_r ? rd_f : is_lw ? rt : '0;
            if (issue) begin
                A      <= rs_val;
                B      <= rt_val;
                IMM    <= imm_ext;
                ALUctr <= alu_nxt;
                ALUsrc <= is_lw | is_sw;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected D/X contents are queued as each
// instruction is driven and compared one edge later; combinational outputs are checked directly.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic [4:0]  mw_rd;
    logic [31:0] mw_alu;
    logic [31:0] a, b, imm, redirect_pc;
    logic [4:0]  rd;
    logic [2:0]  alu_ctr;
    logic        alu_src, lw_flag, sw_flag, dx_valid, stall, redirect;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .IR(ir), .IR_valid(ir_valid), .PC(pc),
        .MW_RD(mw_rd), .MW_ALUout(mw_alu),
        .A(a), .B(b), .IMM(imm), .RD(rd), .ALUctr(alu_ctr), .ALUsrc(alu_src),
        .DX_lwFlag(lw_flag), .DX_swFlag(sw_flag), .DX_valid(dx_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic        src, lw, sw, vld;
        bit          ca, cb, ci, cal;
    } dx_t;

    dx_t         exp_q[$];
    logic [31:0] rf_m [32];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rdn, input int fn);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rdn) << 11) | 32'(fn);
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] im);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | {16'h0, im};
    endfunction

    function automatic logic [31:0] rf_rd(input int i);
        if (i == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (int'(mw_rd) == i) return mw_alu;
`endif
        return rf_m[i];
    endfunction

    function automatic dx_t bub();
        dx_t e;
        e = '{a:0, b:0, imm:0, rd:0, alu:0, src:0, lw:0, sw:0, vld:0, ca:0, cb:0, ci:0, cal:0};
        return e;
    endfunction

    function automatic dx_t issued(input logic [31:0] av, input bit ca, input logic [31:0] bv, input bit cb,
                                   input logic [31:0] iv, input bit ci, input int rdn, input int alu,
                                   input logic src, input logic lw, input logic sw);
        dx_t e;
        e = '{a:av, b:bv, imm:iv, rd:5'(rdn), alu:3'(alu), src:src, lw:lw, sw:sw, vld:1'b1,
              ca:ca, cb:cb, ci:ci, cal:1'b1};
        return e;
    endfunction

    function automatic dx_t all_zero();
        dx_t e;
        e = '{a:0, b:0, imm:0, rd:0, alu:0, src:0, lw:0, sw:0, vld:0, ca:1, cb:1, ci:1, cal:1};
        return e;
    endfunction

    task automatic comb_chk(input string tag, input logic exp_stall, input logic exp_redir);
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        check({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
    endtask

    // Queue the expectation, clock once, update the register model, then compare.
    task automatic cycle(input string tag, input dx_t e);
        dx_t got_e;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        end else if (mw_rd != 5'd0) begin
            rf_m[mw_rd] = mw_alu;
        end
        #1;
        got_e = exp_q.pop_front();
        check({tag, ".vld"}, 32'(dx_valid), 32'(got_e.vld));
        check({tag, ".rd"},  32'(rd),       32'(got_e.rd));
        check({tag, ".lw"},  32'(lw_flag),  32'(got_e.lw));
        check({tag, ".sw"},  32'(sw_flag),  32'(got_e.sw));
        if (got_e.ca)  check({tag, ".A"},   a,   got_e.a);
        if (got_e.cb)  check({tag, ".B"},   b,   got_e.b);
        if (got_e.ci)  check({tag, ".IMM"}, imm, got_e.imm);
        if (got_e.cal) begin
            check({tag, ".alu"}, 32'(alu_ctr), 32'(got_e.alu));
            check({tag, ".src"}, 32'(alu_src), 32'(got_e.src));
        end
    endtask

    task automatic wb(input int r, input logic [31:0] v);
        ir_valid = 1'b0;
        mw_rd    = 5'(r);
        mw_alu   = v;
        cycle("wb", bub());
        mw_rd    = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = 32'hDEAD_BEEF;
        rst = 1'b1; ir = 32'h0; ir_valid = 1'b0; pc = 32'h0; mw_rd = 5'd0; mw_alu = 32'h0;
        cycle("reset", all_zero());
        cycle("reset2", all_zero());
        rst = 1'b0;
        comb_chk("post_reset", 1'b0, 1'b0);

        // add $3,$1,$2
        wb(1, 32'd5);
        wb(2, 32'd7);
        ir = rtype(1, 2, 3, 32); ir_valid = 1'b1;
        comb_chk("add", 1'b0, 1'b0);
        cycle("add", issued(32'd5, 1, 32'd7, 1, 32'h0, 0, 3, 0, 0, 0, 0));

        // lw $4,8($1) then sub $5,$4,$1 (load-use)
        ir = itype(35, 1, 4, 16'd8);
        comb_chk("lw", 1'b0, 1'b0);
        cycle("lw", issued(32'd5, 1, 32'h0, 0, 32'd8, 1, 4, 0, 1, 1, 0));
        ir = rtype(4, 1, 5, 34);
        comb_chk("sub_stall", 1'b1, 1'b0);
        cycle("sub_stall", bub());
        comb_chk("sub_go", 1'b0, 1'b0);
        cycle("sub_go", issued(rf_rd(4), 1, 32'd5, 1, 32'h0, 0, 5, 1, 0, 0, 0));

        // sw $2,-4($1)
        ir = itype(43, 1, 2, 16'hFFFC);
        comb_chk("sw", 1'b0, 1'b0);
        cycle("sw", issued(32'd5, 1, 32'd7, 1, 32'hFFFF_FFFC, 1, 0, 0, 1, 0, 1));

        // beq taken / not taken
        wb(1, 32'd9);
        wb(2, 32'd9);
        pc = 32'h100; ir = itype(4, 1, 2, 16'd3); ir_valid = 1'b1;
        comb_chk("beq_taken", 1'b0, 1'b1);
        check("beq_taken.pc", redirect_pc, 32'h110);
        cycle("beq_taken", bub());
        wb(2, 32'd8);
        ir = itype(4, 1, 2, 16'd3); ir_valid = 1'b1;
        comb_chk("beq_nt", 1'b0, 1'b0);
        cycle("beq_nt", bub());

        // branch hazard on an ALU result in D/X
        ir = rtype(2, 2, 6, 37);
        cycle("or", issued(32'd8, 1, 32'd8, 1, 32'h0, 0, 6, 4, 0, 0, 0));
        ir = itype(4, 6, 1, 16'hFFFF);
        comb_chk("beq_hz", 1'b1, 1'b0);
        cycle("beq_hz", bub());
        comb_chk("beq_hz_go", 1'b0, 1'b0);
        check("beq_hz_go.pc", redirect_pc, 32'h100);
        cycle("beq_hz_go", bub());

        // jump
        pc = 32'h4000_0010; ir = (32'd2 << 26) | 32'h20;
        comb_chk("j", 1'b0, 1'b1);
        check("j.pc", redirect_pc, 32'h4000_0080);
        cycle("j", bub());

        // unsupported funct / opcode, invalid IR
        ir = rtype(1, 2, 3, 63);
        comb_chk("bad_fn", 1'b0, 1'b0);
        cycle("bad_fn", bub());
        ir = itype(8, 1, 2, 16'd5);
        comb_chk("bad_op", 1'b0, 1'b0);
        cycle("bad_op", bub());
        ir = itype(4, 1, 1, 16'd1); ir_valid = 1'b0;
        comb_chk("invalid", 1'b0, 1'b0);
        cycle("invalid", bub());

        // same-cycle write-back and read of $6
        ir = rtype(6, 0, 7, 32); ir_valid = 1'b1; mw_rd = 5'd6; mw_alu = 32'hAA;
        cycle("wb_same", issued(rf_rd(6), 1, 32'h0, 1, 32'h0, 0, 7, 0, 0, 0, 0));
        ir = rtype(0, 6, 8, 32); mw_rd = 5'd0; mw_alu = 32'hFF;
        cycle("wb_after", issued(32'h0, 1, 32'hAA, 1, 32'h0, 0, 8, 0, 0, 0, 0));
        ir = rtype(0, 0, 9, 36);
        cycle("r0", issued(32'h0, 1, 32'h0, 1, 32'h0, 0, 9, 3, 0, 0, 0));

        // reset during a load-use stall
        ir = itype(35, 1, 4, 16'd8);
        cycle("lw2", issued(32'd9, 1, 32'h0, 0, 32'd8, 1, 4, 0, 1, 1, 0));
        ir = rtype(4, 1, 5, 42);
        comb_chk("stall2", 1'b1, 1'b0);
        rst = 1'b1;
        cycle("rst_stall", all_zero());
        rst = 1'b0; ir_valid = 1'b0;
        comb_chk("after_rst", 1'b0, 1'b0);
        cycle("after_rst", bub());
        ir = rtype(1, 0, 9, 32); ir_valid = 1'b1;
        cycle("r1_cleared", issued(32'h0, 1, 32'h0, 1, 32'h0, 0, 9, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
